// File: rtl/seg7_pkg.sv
// seg7_pkg: converter states, display sizes and active-low segment codes
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_DIGITS = 5;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/seg7_display_driver_if.sv
// seg7_display_driver_if: value input and display/status outputs of the driver
interface seg7_display_driver_if;
  logic [15:0] value;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic        overflow;
  modport master (output value, input an, seg, dp, busy, overflow);
  modport slave (input value, output an, seg, dp, busy, overflow);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one bit per cycle, 16 shifts then a DONE cycle
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);
  conv_state_e             r_state;
  logic [15:0]             r_shift;
  logic [4*BCD_DIGITS-1:0] r_bcd;
  logic [3:0]              r_cnt;
  logic [4*BCD_DIGITS-1:0] w_adj;
  for (genvar n = 0; n < BCD_DIGITS; n++) begin : g_adj
    assign w_adj[4*n +: 4] = r_bcd[4*n +: 4] >= 4'd5 ? r_bcd[4*n +: 4] + 4'd3 : r_bcd[4*n +: 4];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_shift <= bin;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          {r_bcd, r_shift} <= {w_adj, r_shift} << 1;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign bcd  = r_bcd;
endmodule

// File: rtl/seg7_display_driver.sv
// seg7_display_driver: 4-digit multiplexed active-low 7-seg driver; SIGNED_DISPLAY_EN selects two's complement input
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int DIGIT_PERIOD = 100000
) (
  input logic                  clk,
  input logic                  reset,
  seg7_display_driver_if.slave bus
);
  localparam int CW = DIGIT_PERIOD > 1 ? $clog2(DIGIT_PERIOD) : 1;
  logic                    w_start, w_busy, w_done, w_ovf, w_neg, w_wrap;
  logic [15:0]             w_bin;
  logic [4*BCD_DIGITS-1:0] w_bcd;
  logic [3:0]              w_nz;
  logic [6:0]              w_seg;
  logic [15:0]             r_cap, r_last;
  logic                    r_force, r_ovf;
  logic [3:0]              r_dig [NUM_DIGITS];
  logic [CW-1:0]           r_refresh;
  logic [1:0]              r_idx;
  logic [3:0]              r_an;
  logic [6:0]              r_seg;
  // r_cap remembers the value actually converted, so later input changes are re-compared
  assign w_start = !w_busy && (bus.value != r_last || r_force);
`ifdef SIGNED_DISPLAY_EN
  logic r_neg;
  assign w_bin = bus.value[15] ? -bus.value : bus.value;
  assign w_ovf = r_cap[15] ? |w_bcd[19:12] : |w_bcd[19:16];
  assign w_neg = r_neg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_neg <= 1'b0;
    else if (w_done) r_neg <= r_cap[15];
  end
`else
  assign w_bin = bus.value;
  assign w_ovf = |w_bcd[19:16];
  assign w_neg = 1'b0;
`endif
  bin2bcd_seq u_conv (
    .clk(clk),
    .reset(reset),
    .start(w_start),
    .bin(w_bin),
    .busy(w_busy),
    .done(w_done),
    .bcd(w_bcd)
  );
  assign w_wrap = r_refresh == CW'(DIGIT_PERIOD - 1);
  assign w_nz = {|r_dig[3], |{r_dig[3], r_dig[2]}, |{r_dig[3], r_dig[2], r_dig[1]}, 1'b1};
  assign w_seg = (r_ovf || (w_neg && r_idx == 2'd3)) ? SEG_DASH :
                 !w_nz[r_idx] ? SEG_BLANK : seg_encode(r_dig[r_idx]);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap     <= '0;
      r_last    <= '0;
      r_force   <= 1'b1;
      r_dig     <= '{default: '0};
      r_ovf     <= 1'b0;
      r_refresh <= '0;
      r_idx     <= '0;
      r_an      <= 4'hF;
      r_seg     <= SEG_BLANK;
    end else begin
      if (w_start) begin
        r_cap   <= bus.value;
        r_force <= 1'b0;
      end
      if (w_done) begin
        for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= w_bcd[4*i +: 4];
        r_ovf  <= w_ovf;
        r_last <= r_cap;
      end
      r_refresh <= w_wrap ? '0 : r_refresh + CW'(1);
      if (w_wrap) r_idx <= r_idx + 2'd1;
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_seg;
    end
  end
  assign bus.an       = r_an;
  assign bus.seg      = r_seg;
  assign bus.dp       = 1'b1;
  assign bus.busy     = w_busy;
  assign bus.overflow = r_ovf;
endmodule
